// File: rtl/ddr_pkg.sv
// ddr_pkg: shared AXI write-command entry type plus response codes and burst limits.
package ddr_pkg;
   localparam int WCMD_ADDR_W = 32;
   localparam int WCMD_ID_W = 4;
   localparam logic [1:0] BRESP_OKAY = 2'd0;
   localparam logic [1:0] BRESP_SLVERR = 2'd2;
   localparam logic [7:0] MAX_BURST_LEN = 8'd15;
   localparam logic [2:0] MAX_AXSIZE = 3'd3;
   typedef struct packed {
      logic [WCMD_ADDR_W-1:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [WCMD_ID_W-1:0] id;
      logic err;
   } wcmd_t;
endpackage

// File: rtl/wcmd_mem.sv
// wcmd_mem: DEPTH x wcmd_t register array, one write port, one asynchronous read port.
module wcmd_mem import ddr_pkg::*; #(
   parameter int DEPTH = 8,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  wcmd_t         wdata,
   input  logic [PW-1:0] raddr,
   output wcmd_t         rdata
);
   wcmd_t mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/write_cmd_queue.sv
// write_cmd_queue: circular queue of AXI write-address commands with per-entry error flag.
// Define WCMD_ALIGN_CHECK_EN to also flag addresses misaligned to 2^AWSIZE bytes.
module write_cmd_queue import ddr_pkg::*; #(
   parameter int DEPTH = 8,
   parameter int ADDR_W = 32,
   parameter int ID_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              pop,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic [7:0]        AWLEN,
   input  logic [2:0]        AWSIZE,
   input  logic [ID_W-1:0]   AWID,
   output logic [3:0]        num_transactions,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_addr,
   output logic [7:0]        head_len,
   output logic [2:0]        head_size,
   output logic [ID_W-1:0]   head_id,
   output logic              err,
   output logic              overflow,
   output logic              underflow
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [3:0] cnt;
   logic empty, full, do_pop, do_push, bad;
   wcmd_t wr_entry, head;
   assign empty = cnt == 4'd0;
   assign full = cnt == 4'(DEPTH);
   assign do_pop = pop && !empty;
   // A pop on a full queue frees the slot the same cycle, so the push still lands.
   assign do_push = load && (!full || do_pop);
`ifdef WCMD_ALIGN_CHECK_EN
   assign bad = (AWLEN > MAX_BURST_LEN) || (AWSIZE > MAX_AXSIZE) ||
                (|(AWADDR & ~({ADDR_W{1'b1}} << AWSIZE)));
`else
   assign bad = (AWLEN > MAX_BURST_LEN) || (AWSIZE > MAX_AXSIZE);
`endif
   assign wr_entry = '{addr: WCMD_ADDR_W'(AWADDR), len: AWLEN, size: AWSIZE,
                       id: WCMD_ID_W'(AWID), err: bad};
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + 4'(do_push) - 4'(do_pop);
         if (load && full && !pop) overflow <= 1'b1;
         if (pop && empty) underflow <= 1'b1;
      end
   end
   wcmd_mem #(.DEPTH(DEPTH)) u_mem (
      .clk(clk),
      .we(do_push && !rst),
      .waddr(wr_ptr),
      .wdata(wr_entry),
      .raddr(rd_ptr),
      .rdata(head)
   );
   assign num_transactions = cnt;
   assign head_valid = !empty;
   assign head_addr = ADDR_W'(head.addr);
   assign head_len = head.len;
   assign head_size = head.size;
   assign head_id = ID_W'(head.id);
   assign err = !empty && head.err;
endmodule

// File: tb/tb_write_cmd_queue.sv
// tb_write_cmd_queue: scoreboard bench for write_cmd_queue (honours WCMD_ALIGN_CHECK_EN).
module tb_write_cmd_queue;
   typedef struct {
      logic [31:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [3:0] id;
      logic e;
   } ent_t;
   logic clk = 1'b0, rst = 1'b0, load = 1'b0, pop = 1'b0;
   logic [31:0] AWADDR = '0;
   logic [7:0] AWLEN = '0;
   logic [2:0] AWSIZE = '0;
   logic [3:0] AWID = '0;
   logic [3:0] num_transactions;
   logic head_valid, err, overflow, underflow;
   logic [31:0] head_addr;
   logic [7:0] head_len;
   logic [2:0] head_size;
   logic [3:0] head_id;
   ent_t q[$];
   logic m_ovf = 1'b0, m_unf = 1'b0;
   int total = 0, bad = 0;

   write_cmd_queue #(.DEPTH(8), .ADDR_W(32), .ID_W(4)) dut (
      .clk(clk), .rst(rst), .load(load), .pop(pop), .AWADDR(AWADDR), .AWLEN(AWLEN),
      .AWSIZE(AWSIZE), .AWID(AWID), .num_transactions(num_transactions),
      .head_valid(head_valid), .head_addr(head_addr), .head_len(head_len),
      .head_size(head_size), .head_id(head_id), .err(err), .overflow(overflow),
      .underflow(underflow)
   );
   always #5 clk = ~clk;

   function automatic logic exp_err(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
      logic e;
      e = (l > 8'd15) || (s > 3'd3);
`ifdef WCMD_ALIGN_CHECK_EN
      if ((a % (32'd1 << s)) != 0) e = 1'b1;
`endif
      return e;
   endfunction

   task automatic cycle(input logic l, input logic p, input logic [31:0] a,
                        input logic [7:0] ln, input logic [2:0] s, input logic [3:0] i);
      bit pp, pu;
      load = l; pop = p; AWADDR = a; AWLEN = ln; AWSIZE = s; AWID = i;
      pp = p && q.size() > 0;
      pu = l && (q.size() < 8 || pp);
      if (l && q.size() == 8 && !p) m_ovf = 1'b1;
      if (p && q.size() == 0) m_unf = 1'b1;
      if (pp) void'(q.pop_front());
      if (pu) q.push_back('{addr: a, len: ln, size: s, id: i, e: exp_err(a, ln, s)});
      @(posedge clk); #1;
      load = 1'b0; pop = 1'b0;
   endtask

   task automatic do_reset(input logic l, input logic p);
      rst = 1'b1; load = l; pop = p;
      @(posedge clk); #1;
      rst = 1'b0; load = 1'b0; pop = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      total += 5;
      if (num_transactions !== 4'd0) begin bad++; $display("FAIL reset_num got=%0d want=0", num_transactions); end
      if (head_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", head_valid); end
      if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      if (underflow !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b want=0", underflow); end
   endtask

   task automatic test_basic();
      do_reset(1'b0, 1'b0);
      cycle(1, 0, 32'h100, 8'd3, 3'd3, 4'd5);
      total += 7;
      if (head_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", head_valid); end
      if (head_addr !== 32'h100) begin bad++; $display("FAIL basic_addr got=%h want=100", head_addr); end
      if (head_len !== 8'd3) begin bad++; $display("FAIL basic_len got=%0d want=3", head_len); end
      if (head_size !== 3'd3) begin bad++; $display("FAIL basic_size got=%0d want=3", head_size); end
      if (head_id !== 4'd5) begin bad++; $display("FAIL basic_id got=%0d want=5", head_id); end
      if (num_transactions !== 4'd1) begin bad++; $display("FAIL basic_num got=%0d want=1", num_transactions); end
      if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
   endtask

   task automatic fill8();
      for (int i = 0; i < 8; i++) cycle(1, 0, 32'h1000 + 32'(i * 8), 8'(i), 3'd3, 4'(i));
   endtask

   task automatic test_overflow();
      do_reset(1'b0, 1'b0);
      fill8();
      total += 2;
      if (num_transactions !== 4'd8) begin bad++; $display("FAIL full_num got=%0d want=8", num_transactions); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_early got=%b want=0", overflow); end
      cycle(1, 0, 32'h9999_0000, 8'd1, 3'd2, 4'd9);
      total += 4;
      if (num_transactions !== 4'd8) begin bad++; $display("FAIL ovf_num got=%0d want=8", num_transactions); end
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      if (head_addr !== 32'h1000) begin bad++; $display("FAIL ovf_head got=%h want=1000", head_addr); end
      if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_unf got=%b want=0", underflow); end
      do_reset(1'b1, 1'b0);
      total += 2;
      if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
      if (num_transactions !== 4'd0) begin bad++; $display("FAIL midreset_num got=%0d want=0", num_transactions); end
   endtask

   task automatic test_full_push_pop();
      do_reset(1'b0, 1'b0);
      fill8();
      cycle(1, 1, 32'h2000, 8'd7, 3'd1, 4'hA);
      total += 3;
      if (num_transactions !== 4'd8) begin bad++; $display("FAIL fpp_num got=%0d want=8", num_transactions); end
      if (head_addr !== 32'h1008) begin bad++; $display("FAIL fpp_head got=%h want=1008", head_addr); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
      for (int i = 0; i < 7; i++) begin
         cycle(0, 1, '0, '0, '0, '0);
         total++;
         if (head_addr !== q[0].addr) begin bad++; $display("FAIL fpp_drain%0d got=%h want=%h", i, head_addr, q[0].addr); end
      end
      total += 3;
      if (head_addr !== 32'h2000) begin bad++; $display("FAIL fpp_tail got=%h want=2000", head_addr); end
      if (head_id !== 4'hA) begin bad++; $display("FAIL fpp_tail_id got=%h want=a", head_id); end
      if (num_transactions !== 4'd1) begin bad++; $display("FAIL fpp_tail_num got=%0d want=1", num_transactions); end
   endtask

   task automatic test_err();
      do_reset(1'b0, 1'b0);
      cycle(1, 0, 32'h200, 8'd16, 3'd2, 4'd1);
      cycle(1, 0, 32'h300, 8'd1, 3'd2, 4'd2);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_len got=%b want=1", err); end
      cycle(0, 1, '0, '0, '0, '0);
      total += 2;
      if (err !== 1'b0) begin bad++; $display("FAIL err_good got=%b want=0", err); end
      if (head_addr !== 32'h300) begin bad++; $display("FAIL err_head got=%h want=300", head_addr); end
      cycle(1, 1, 32'h0, 8'd0, 3'd4, 4'd3);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_size got=%b want=1", err); end
      cycle(0, 1, '0, '0, '0, '0);
      total += 2;
      if (err !== 1'b0) begin bad++; $display("FAIL err_empty got=%b want=0", err); end
      if (head_valid !== 1'b0) begin bad++; $display("FAIL err_empty_valid got=%b want=0", head_valid); end
   endtask

   task automatic test_underflow();
      do_reset(1'b0, 1'b0);
      cycle(1, 1, 32'h400, 8'd2, 3'd3, 4'd7);
      total += 4;
      if (underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b want=1", underflow); end
      if (num_transactions !== 4'd1) begin bad++; $display("FAIL unf_num got=%0d want=1", num_transactions); end
      if (head_addr !== 32'h400) begin bad++; $display("FAIL unf_head got=%h want=400", head_addr); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL unf_ovf got=%b want=0", overflow); end
      cycle(0, 1, '0, '0, '0, '0);
      total++;
      if (underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b want=1", underflow); end
   endtask

   task automatic test_align();
      logic want;
`ifdef WCMD_ALIGN_CHECK_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      do_reset(1'b0, 1'b0);
      cycle(1, 0, 32'h104, 8'd0, 3'd3, 4'd0);
      total++;
      if (err !== want) begin bad++; $display("FAIL align_err got=%b want=%b", err, want); end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0, 1'b0);
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
               $urandom & 32'hFFFF_FFF8 | 32'($urandom_range(0, 1) * 4),
               8'($urandom_range(0, 20)), 3'($urandom_range(0, 4)), 4'($urandom));
         total += 5;
         if (num_transactions !== 4'(q.size())) begin bad++; $display("FAIL rnd%0d_num got=%0d want=%0d", n, num_transactions, q.size()); end
         if (head_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", n, head_valid, q.size() != 0); end
         if (overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf got=%b want=%b", n, overflow, m_ovf); end
         if (underflow !== m_unf) begin bad++; $display("FAIL rnd%0d_unf got=%b want=%b", n, underflow, m_unf); end
         if (err !== (q.size() != 0 && q[0].e)) begin bad++; $display("FAIL rnd%0d_err got=%b want=%b", n, err, q.size() != 0 && q[0].e); end
         if (q.size() != 0) begin
            total++;
            if ({head_addr, head_len, head_size, head_id} !== {q[0].addr, q[0].len, q[0].size, q[0].id}) begin
               bad++;
               $display("FAIL rnd%0d_head got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d", n, head_addr, head_len,
                        head_size, head_id, q[0].addr, q[0].len, q[0].size, q[0].id);
            end
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_err();
      test_underflow();
      test_align();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
